sync_debounce: RTL and testbench

Input conditioning stage placed directly upstream of the rising-edge pulse detector. It synchronizes an asynchronous raw input (button, strap, external flag) into `clk` and rejects any level change that does not stay stable for a programmable number of cycles. The output is a clean, glitch-free, registered level that the edge detector samples directly. A saturating counter reports how many transitions were rejected.

---
 rtl/sync_debounce_if.sv | 9 +
 rtl/sync_debounce.sv | 69 ++++++
 tb/tb_sync_debounce.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sync_debounce_if.sv
// sync_debounce_if: bundles the debouncer's data, control and status signals
//   master: drives data_in, glitch_clr; observes data_out, busy, glitch_cnt
//   slave : the debouncer side
interface sync_debounce_if #(parameter int GLITCH_W = 8);
   logic data_in, glitch_clr, data_out, busy;
   logic [GLITCH_W-1:0] glitch_cnt;
   modport master (output data_in, glitch_clr, input data_out, busy, glitch_cnt);
   modport slave  (input data_in, glitch_clr, output data_out, busy, glitch_cnt);
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: synchronize an async level and pass a change only after N+1 stable samples
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : data_in (raw async level), glitch_clr (sync clear) in;
//                 data_out (debounced, registered), busy (qualifying), glitch_cnt (saturating) out
module sync_debounce #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int GLITCH_W      = 8
) (
   input logic clk,
   input logic rst_n,
   sync_debounce_if.slave bus
);
   localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
   typedef enum logic [1:0] {S_LOW, CHK_H, S_HIGH, CHK_L} state_t;
   state_t state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0] cnt_q;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;
   logic data_q, sync, glitch;
   assign sync = sync_q[SYNC_STAGES-1];
   // a check state seeing the old level again abandons the candidate
   assign glitch = (state_q == CHK_H && !sync) || (state_q == CHK_L && sync);
   // clear wins over a same-cycle glitch; count holds at all-ones
   assign glitch_d = bus.glitch_clr ? '0 : (glitch && !(&glitch_q)) ? glitch_q + GLITCH_W'(1) : glitch_q;
   assign bus.data_out = data_q;
   assign bus.busy = state_q == CHK_H || state_q == CHK_L;
   assign bus.glitch_cnt = glitch_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_q <= '0;
         glitch_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_in};
         glitch_q <= glitch_d;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_LOW;
         cnt_q <= '0;
         data_q <= 1'b0;
      end else
         case (state_q)
            S_LOW:
               if (sync) begin
                  state_q <= CHK_H;
                  cnt_q <= '0;
               end
            CHK_H:
               if (!sync) state_q <= S_LOW;
               else if (cnt_q == LAST) begin
                  state_q <= S_HIGH;
                  data_q <= 1'b1;
               end else cnt_q <= cnt_q + CW'(1);
            S_HIGH:
               if (!sync) begin
                  state_q <= CHK_L;
                  cnt_q <= '0;
               end
            CHK_L:
               if (sync) state_q <= S_HIGH;
               else if (cnt_q == LAST) begin
                  state_q <= S_LOW;
                  data_q <= 1'b0;
               end else cnt_q <= cnt_q + CW'(1);
            default: state_q <= S_LOW;
         endcase
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: randomized and directed checks of sync_debounce against a run-length reference model
module tb_sync_debounce;
   localparam int SS = 2;
   localparam int N = 4;
   localparam int GW = 4;
   localparam int GMAX = (1 << GW) - 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errs = 0;
   int checks = 0;
   logic pipe[$];
   logic m_out;
   int run;
   int m_gc;
   sync_debounce_if #(.GLITCH_W(GW)) bus();
   sync_debounce #(.SYNC_STAGES(SS), .STABLE_CYCLES(N), .GLITCH_W(GW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(string tag, int got, int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic mdl_reset();
      pipe.delete();
      for (int i = 0; i < SS; i++) pipe.push_back(1'b0);
      m_out = 1'b0;
      run = 0;
      m_gc = 0;
   endtask
   // one clock edge: model sees the level sampled SS edges ago; a level differing from the
   // output for N+1 samples in a row is accepted, a shorter differing run is a glitch
   task automatic tick();
      logic s, g;
      @(posedge clk);
      if (!rst_n) mdl_reset();
      else begin
         s = pipe.pop_front();
         pipe.push_back(bus.data_in);
         g = 1'b0;
         if (s != m_out) begin
            run++;
            if (run == N + 1) begin
               m_out = s;
               run = 0;
            end
         end else begin
            g = run > 0;
            run = 0;
         end
         if (bus.glitch_clr) m_gc = 0;
         else if (g && m_gc < GMAX) m_gc++;
      end
      @(negedge clk);
      check("data_out", int'(bus.data_out), int'(m_out));
      check("busy", int'(bus.busy), int'(run > 0));
      check("glitch_cnt", int'(bus.glitch_cnt), m_gc);
   endtask
   task automatic hold(int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   // drive lvl for w edges (then !lvl) and report the edge at which data_out reaches lvl
   task automatic measure(string tag, logic lvl, int w, int exp);
      int n = 0;
      int b = 0;
      for (int i = 1; i <= 30 && n == 0; i++) begin
         bus.data_in = (i <= w) ? lvl : !lvl;
         tick();
         if (bus.data_out == lvl) n = i;
         else b += int'(bus.busy);
      end
      check({tag, " edge"}, n, exp);
      check({tag, " busy"}, b, N);
   endtask
   task automatic pulse(logic lvl, int w, int gap);
      bus.data_in = lvl;
      hold(w);
      bus.data_in = !lvl;
      hold(gap);
   endtask
   task automatic clear();
      bus.glitch_clr = 1'b1;
      tick();
      bus.glitch_clr = 1'b0;
   endtask
   initial begin
      mdl_reset();
      bus.data_in = 1'b1;
      bus.glitch_clr = 1'b0;
      hold(3);
      check("reset data_out", int'(bus.data_out), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset glitch_cnt", int'(bus.glitch_cnt), 0);
      rst_n = 1'b1;
      measure("t1 rise", 1'b1, 99, 7);
      hold(20);
      measure("t2 fall", 1'b0, 99, 7);
      hold(20);
      measure("t2 rise", 1'b1, 99, 7);
      hold(20);
      measure("t2 fall2", 1'b0, 99, 7);
      hold(20);
      check("t2 glitch_cnt", int'(bus.glitch_cnt), 0);
      pulse(1'b1, 4, 12);
      check("t3 w4 data_out", int'(bus.data_out), 0);
      check("t3 w4 glitch_cnt", int'(bus.glitch_cnt), 1);
      measure("t3 w5", 1'b1, 5, 7);
      hold(15);
      check("t3 back low", int'(bus.data_out), 0);
      clear();
      for (int i = 0; i < 3; i++) pulse(1'b1, 2, 2);
      measure("t4 bounce", 1'b1, 99, 7);
      check("t4 glitch_cnt", int'(bus.glitch_cnt), 3);
      hold(10);
      bus.data_in = 1'b0;
      hold(20);
      clear();
      for (int i = 0; i < 20; i++) pulse(1'b1, 1, 3);
      check("t5 saturate", int'(bus.glitch_cnt), GMAX);
      bus.data_in = 1'b1;
      tick();
      bus.data_in = 1'b0;
      hold(2);
      check("t5 busy before clr", int'(bus.busy), 1);
      clear();
      check("t5 clr wins", int'(bus.glitch_cnt), 0);
      check("t5 glitch happened", int'(bus.busy), 0);
      hold(5);
      for (int s = 0; s < 60; s++) begin
         bus.data_in = 1'($urandom_range(0, 1));
         for (int k = $urandom_range(1, 8); k > 0; k--) begin
            bus.glitch_clr = ($urandom_range(0, 15) == 0);
            tick();
         end
      end
      bus.glitch_clr = 1'b0;
      bus.data_in = 1'b0;
      hold(20);
      pulse(1'b1, 1, 4);
      bus.data_in = 1'b1;
      hold(5);
      check("t6 in check", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      mdl_reset();
      check("t6 busy", int'(bus.busy), 0);
      check("t6 data_out", int'(bus.data_out), 0);
      check("t6 glitch_cnt", int'(bus.glitch_cnt), 0);
      hold(2);
      rst_n = 1'b1;
      measure("t6 restart", 1'b1, 99, 7);
      hold(5);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
